// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - scan-code constants and PS/2 receiver state encoding
package kbd_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_SPACE = 8'h29;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

endpackage

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 pin synchroniser, clock filter and 11-bit frame receiver
module ps2_rx_frame #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic       byteValid,
    output logic [7:0] rxByte,
    output logic       frameErr
);
    import kbd_pkg::*;

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_dat_sync;
    logic          w_clk_s;
    logic          w_dat_s;
    logic          r_filt_clk;
    logic [FW-1:0] r_filt_cnt;
    logic          r_fall;
    logic          r_fall_dat;
    rx_state_t     r_state;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_par;
    logic [TW-1:0] r_tmo;
    logic          r_byte_valid;
    logic [7:0]    r_byte;
    logic          r_frame_err;

    assign w_clk_s = r_clk_sync[1];
    assign w_dat_s = r_dat_sync[1];

    // Idle bus level is high, so synchronisers and filter reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_filt_clk <= 1'b1;
            r_filt_cnt <= '0;
            r_fall     <= 1'b0;
            r_fall_dat <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2Clk};
            r_dat_sync <= {r_dat_sync[0], ps2Data};
            r_fall     <= 1'b0;
            if (w_clk_s == r_filt_clk) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                r_filt_clk <= w_clk_s;
                r_filt_cnt <= '0;
                r_fall     <= ~w_clk_s;
                r_fall_dat <= w_dat_s;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= IDLE;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_tmo        <= '0;
            r_byte_valid <= 1'b0;
            r_byte       <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (r_state == IDLE || r_fall) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end

            if (r_state != IDLE && !r_fall && r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                r_state     <= IDLE;
                r_frame_err <= 1'b1;
                r_tmo       <= '0;
            end else if (r_fall) begin
                case (r_state)
                    IDLE: begin
                        if (!r_fall_dat) begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                        end
                    end
                    DATA: begin
                        r_shift   <= {r_fall_dat, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= PARITY;
                        end
                    end
                    PARITY: begin
                        r_par   <= r_fall_dat;
                        r_state <= STOP;
                    end
                    STOP: begin
                        r_state <= IDLE;
                        if (r_fall_dat && (^{r_shift, r_par})) begin
                            r_byte_valid <= 1'b1;
                            r_byte       <= r_shift;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign byteValid = r_byte_valid;
    assign rxByte    = r_byte;
    assign frameErr  = r_frame_err;

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 scan-code decoder for arrow and space player controls
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic resetN,
    input  logic ps2Clk,
    input  logic ps2Data,
    output logic rightArrow,
    output logic leftArrow,
    output logic spaceBar,
    output logic spaceHeld,
    output logic frameErr
);
    import kbd_pkg::*;

    logic       w_byte_valid;
    logic [7:0] w_byte;
    logic       w_frame_err;
    logic       r_ext;
    logic       r_brk;
    logic [2:0] r_skip;
    logic       r_right;
    logic       r_left;
    logic       r_space_pulse;
    logic       r_space_held;

    ps2_rx_frame #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk      (clk),
        .resetN   (resetN),
        .ps2Clk   (ps2Clk),
        .ps2Data  (ps2Data),
        .byteValid(w_byte_valid),
        .rxByte   (w_byte),
        .frameErr (w_frame_err)
    );

    // The skip window is checked first so the second E1 inside the pause sequence is swallowed.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_ext         <= 1'b0;
            r_brk         <= 1'b0;
            r_skip        <= '0;
            r_right       <= 1'b0;
            r_left        <= 1'b0;
            r_space_pulse <= 1'b0;
            r_space_held  <= 1'b0;
        end else begin
            r_space_pulse <= 1'b0;
            if (w_byte_valid) begin
                if (r_skip != 3'd0) begin
                    r_skip <= r_skip - 1'b1;
                end else if (w_byte == SC_PAUSE) begin
                    r_skip <= 3'd7;
                end else if (w_byte == SC_EXT) begin
                    r_ext <= 1'b1;
                end else if (w_byte == SC_BREAK) begin
                    r_brk <= 1'b1;
                end else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                    if (r_ext && w_byte == SC_RIGHT) begin
                        r_right <= ~r_brk;
                    end
                    if (r_ext && w_byte == SC_LEFT) begin
                        r_left <= ~r_brk;
                    end
                    if (!r_ext && w_byte == SC_SPACE) begin
                        r_space_held  <= ~r_brk;
                        r_space_pulse <= ~r_brk & ~r_space_held;
                    end
                end
            end
        end
    end

    assign rightArrow = r_right;
    assign leftArrow  = r_left;
    assign spaceBar   = r_space_pulse;
    assign spaceHeld  = r_space_held;
    assign frameErr   = w_frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - self-checking bench for ps2_key_decoder
module tb_ps2_key_decoder;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 2000;
    localparam int HP         = 20;
    localparam int LAT_SB     = FILTER_LEN + 4;
    localparam int LAT_FE     = FILTER_LEN + 3;

    logic clk = 1'b0;
    logic resetN;
    logic ps2Clk;
    logic ps2Data;
    logic rightArrow, leftArrow, spaceBar, spaceHeld, frameErr;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int stop_fall_cyc = 0;

    int  sb_high = 0, sb_pulses = 0, sb_rise_cyc = 0;
    int  fe_high = 0, fe_pulses = 0, fe_rise_cyc = 0;
    bit  sb_prev = 0, fe_prev = 0;

    bit         m_right = 0, m_left = 0, m_held = 0;
    int         exp_sb = 0, exp_fe = 0;
    int         pause_left = 0;
    logic [7:0] prefix[$];

    ps2_key_decoder #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .ps2Clk    (ps2Clk),
        .ps2Data   (ps2Data),
        .rightArrow(rightArrow),
        .leftArrow (leftArrow),
        .spaceBar  (spaceBar),
        .spaceHeld (spaceHeld),
        .frameErr  (frameErr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (spaceBar) begin
            sb_high++;
            if (!sb_prev) begin
                sb_pulses++;
                sb_rise_cyc = cyc;
            end
        end
        if (frameErr) begin
            fe_high++;
            if (!fe_prev) begin
                fe_pulses++;
                fe_rise_cyc = cyc;
            end
        end
        sb_prev = spaceBar;
        fe_prev = frameErr;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: prefix bytes accumulate until a key byte consumes them.
    task automatic model_byte(input logic [7:0] b, output bit pulsed);
        bit is_ext, is_brk;
        pulsed = 0;
        if (pause_left > 0) begin
            pause_left--;
        end else if (b == 8'hE1) begin
            pause_left = 7;
        end else if (b == 8'hE0 || b == 8'hF0) begin
            prefix.push_back(b);
        end else begin
            is_ext = 0;
            is_brk = 0;
            foreach (prefix[i]) begin
                if (prefix[i] == 8'hE0) is_ext = 1;
                if (prefix[i] == 8'hF0) is_brk = 1;
            end
            prefix.delete();
            if (is_ext && b == 8'h74) m_right = !is_brk;
            if (is_ext && b == 8'h6B) m_left = !is_brk;
            if (!is_ext && b == 8'h29) begin
                if (!is_brk && !m_held) begin
                    pulsed = 1;
                    exp_sb++;
                end
                m_held = !is_brk;
            end
        end
    endtask

    task automatic model_reset();
        m_right = 0;
        m_left = 0;
        m_held = 0;
        pause_left = 0;
        prefix.delete();
    endtask

    task automatic ps2_bit(input logic v, input bit is_stop);
        @(negedge clk);
        ps2Data = v;
        repeat (HP / 2) @(negedge clk);
        ps2Clk = 1'b0;
        if (is_stop) stop_fall_cyc = cyc;
        repeat (HP) @(negedge clk);
        ps2Clk = 1'b1;
        repeat (HP / 2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        ps2_bit(1'b0, 0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 0);
        ps2_bit((~^b) ^ bad_par, 0);
        ps2_bit(~bad_stop, 1);
        ps2Data = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_right"}, rightArrow, m_right);
        check_eq({tag, "_left"}, leftArrow, m_left);
        check_eq({tag, "_held"}, spaceHeld, m_held);
        check_eq({tag, "_sb_count"}, sb_pulses, exp_sb);
        check_eq({tag, "_fe_count"}, fe_pulses, exp_fe);
    endtask

    task automatic do_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        bit pulsed;
        send_frame(b, bad_par, bad_stop);
        pulsed = 0;
        if (bad_par || bad_stop) exp_fe++;
        else model_byte(b, pulsed);
        check_outputs($sformatf("frame%02h", b));
        if (pulsed) check_eq("sb_latency", sb_rise_cyc - stop_fall_cyc, LAT_SB);
        if (bad_par || bad_stop) check_eq("fe_latency", fe_rise_cyc - stop_fall_cyc, LAT_FE);
    endtask

    task automatic send_seq(input logic [7:0] seq[$]);
        foreach (seq[i]) do_frame(seq[i], 0, 0);
    endtask

    initial begin
        logic [7:0] pool[9];
        pool = '{8'hE0, 8'hF0, 8'h29, 8'h74, 8'h6B, 8'h1C, 8'hE1, 8'h14, 8'h77};
        resetN  = 1'b0;
        ps2Clk  = 1'b1;
        ps2Data = 1'b1;
        repeat (5) @(negedge clk);
        check_outputs("reset");
        check_eq("reset_spacebar", spaceBar, 1'b0);
        resetN = 1'b1;
        repeat (10) @(negedge clk);

        do_frame(8'h29, 0, 0);
        send_seq('{8'h29, 8'h29, 8'h29});
        send_seq('{8'hF0, 8'h29});
        send_seq('{8'hE0, 8'h74, 8'hE0, 8'h6B});
        send_seq('{8'hE0, 8'hF0, 8'h74});
        send_seq('{8'h74, 8'hE0, 8'h74});
        do_frame(8'h29, 1, 0);
        do_frame(8'h29, 0, 1);

        // Truncated frame: start bit plus four data bits, then silence.
        ps2_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 0);
        repeat (TIMEOUT + 60) @(negedge clk);
        exp_fe++;
        check_outputs("timeout");
        do_frame(8'h29, 0, 0);
        send_seq('{8'hF0, 8'h29});
        send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h29});

        for (int n = 0; n < 40; n++) begin
            int r;
            r = int'($urandom_range(0, 19));
            do_frame(pool[$urandom_range(0, 8)], r == 0, r == 1);
        end

        send_seq('{8'hE0, 8'h74});
        ps2_bit(1'b0, 0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b0, 0);
        @(negedge clk);
        resetN = 1'b0;
        #1;
        model_reset();
        check_eq("rst_right", rightArrow, 1'b0);
        check_eq("rst_left", leftArrow, 1'b0);
        check_eq("rst_held", spaceHeld, 1'b0);
        check_eq("rst_spacebar", spaceBar, 1'b0);
        check_eq("rst_frameerr", frameErr, 1'b0);
        ps2Clk  = 1'b1;
        ps2Data = 1'b1;
        repeat (5) @(negedge clk);
        resetN = 1'b1;
        repeat (20) @(negedge clk);
        do_frame(8'h29, 0, 0);

        check_eq("sb_width", sb_high, sb_pulses);
        check_eq("fe_width", fe_high, fe_pulses);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
